// File: rtl/sub_bytes_serial.sv
// Byte-serial AES SubBytes: one shared SBox, 16 bytes per 128-bit state; SUB_BYTES_SBOX_REG_EN adds an SBox output register.
// Latency: out_valid after 16 edges from acceptance (17 with SUB_BYTES_SBOX_REG_EN); one state in flight.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.

// Combinational AES SBox: multiplicative inverse in GF(2^8) (x^254) followed by the affine map.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    logic [7:0] x2, x3, x12, x15, x240, inv;

    always_comb begin
        x2   = gmul(a, a);
        x3   = gmul(x2, a);
        x12  = gmul(gmul(x3, x3), gmul(x3, x3));
        x15  = gmul(x12, x3);
        x240 = gmul(x15, x15);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        // 240 + 12 + 2 = 254; zero maps to zero naturally
        inv  = gmul(gmul(x240, x12), x2);
        s    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module sub_bytes_serial #(
    parameter int NBYTES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] LAST = 4'(NBYTES - 1);

    state_t       state, state_nxt;
    logic [3:0]   cnt;
    logic [127:0] inbuf;
    logic [127:0] outbuf;
    logic [7:0]   sbox_in;
    logic [7:0]   sbox_out;
    logic         issue;
    logic         wr_en;
    logic [3:0]   wr_idx;
    logic [7:0]   wr_dat;
    logic         busy_last;

    // Byte 0 sits in the top bits, so byte k lives at offset 8*(15-k).
    assign sbox_in = inbuf[{LAST - cnt, 3'b000} +: 8];

    aes_sbox u_sbox (
        .a (sbox_in),
        .s (sbox_out)
    );

`ifdef SUB_BYTES_SBOX_REG_EN
    logic [7:0] sreg;
    logic       sreg_vld;
    logic       drain;

    // After the last issue cnt has wrapped to 0 while the register still holds byte 15.
    assign drain     = sreg_vld && (cnt == 4'd0);
    assign issue     = (state == BUSY) && !drain;
    assign wr_en     = sreg_vld;
    assign wr_idx    = cnt - 4'd1;
    assign wr_dat    = sreg;
    assign busy_last = drain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg     <= 8'h00;
            sreg_vld <= 1'b0;
        end else begin
            sreg_vld <= issue;
            if (issue) sreg <= sbox_out;
        end
    end
`else
    assign issue     = (state == BUSY);
    assign wr_en     = issue;
    assign wr_idx    = cnt;
    assign wr_dat    = sbox_out;
    assign busy_last = issue && (cnt == LAST);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inbuf  <= '0;
            outbuf <= '0;
            cnt    <= 4'd0;
        end else begin
            if (state == IDLE && in_valid) begin
                inbuf <= state_in;
                cnt   <= 4'd0;
            end else if (issue) begin
                cnt <= cnt + 4'd1;
            end
            if (wr_en) outbuf[{LAST - wr_idx, 3'b000} +: 8] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = BUSY;
            BUSY:    if (busy_last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // in_ready is qualified by rst_n so it reads 0 while reset is held.
    always_comb begin
        in_ready  = (state == IDLE) && rst_n;
        out_valid = (state == DONE);
        busy      = (state == BUSY);
        state_out = outbuf;
    end
endmodule

// File: tb/tb_sub_bytes_serial.sv
// Directed bench for sub_bytes_serial: reset, FIPS-197 vector, constants, backpressure, mid-BUSY reset, back-to-back.
module tb_sub_bytes_serial;
`ifdef SUB_BYTES_SBOX_REG_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 16;
`endif
    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] SEQ_IN   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] SEQ_OUT  = 128'h638293c31bfc33f5c4eeacea4bc12816;
    localparam logic [127:0] C8F      = {16{8'h8f}};
    localparam logic [127:0] C73      = {16{8'h73}};
    localparam logic [127:0] C00      = {16{8'h00}};
    localparam logic [127:0] C63      = {16{8'h63}};

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;

    int checks = 0;
    int errors = 0;

    sub_bytes_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Stimulus helper: sends one state from IDLE with out_ready=1 and reports what it observed.
    task automatic run_one(input logic [127:0] v, output logic [127:0] res,
                           output int lat, output int bcnt);
        state_in  = v;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat  = 0;
        bcnt = 0;
        res  = '0;
        while (!out_valid && lat < 60) begin
            if (busy) bcnt++;
            lat++;
            @(negedge clk);
        end
        if (!out_valid) lat = -1;
        else res = state_out;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; state_in = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || state_out !== 128'h0) begin
            errors++;
            $display("FAIL reset_hold: in_ready=%b out_valid=%b busy=%b state_out=%h want 0 0 0 0",
                     in_ready, out_valid, busy, state_out);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || state_out !== 128'h0) begin
            errors++;
            $display("FAIL reset_idle: in_ready=%b out_valid=%b busy=%b state_out=%h want 1 0 0 0",
                     in_ready, out_valid, busy, state_out);
        end
    endtask

    task automatic test_fips;
        logic [127:0] res;
        int lat, bcnt;
        run_one(FIPS_IN, res, lat, bcnt);
        checks++;
        if (res !== FIPS_OUT) begin
            errors++;
            $display("FAIL fips_result: got %h want %h", res, FIPS_OUT);
        end
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL fips_latency: got %0d want %0d", lat, LAT);
        end
        checks++;
        if (bcnt !== LAT) begin
            errors++;
            $display("FAIL fips_busy_span: got %0d want %0d", bcnt, LAT);
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fips_post_handshake: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_const;
        logic [127:0] res;
        int lat, bcnt;
        run_one(C8F, res, lat, bcnt);
        checks++;
        if (res !== C73) begin
            errors++;
            $display("FAIL const_8f: got %h want %h", res, C73);
        end
        run_one(C00, res, lat, bcnt);
        checks++;
        if (res !== C63) begin
            errors++;
            $display("FAIL const_00: got %h want %h", res, C63);
        end
    endtask

    task automatic test_backpressure;
        int n;
        out_ready = 1'b0;
        state_in  = C8F;
        in_valid  = 1'b1;
        @(negedge clk);
        state_in = C00;
        n = 0;
        while (!out_valid && n < 60) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_done_reached: out_valid=%b want 1", out_valid);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (state_out !== C73 || in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: state_out=%h in_ready=%b out_valid=%b busy=%b want %h 0 1 0",
                         i, state_out, in_ready, out_valid, busy, C73);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_after_handshake: out_valid=%b in_ready=%b busy=%b want 0 1 0",
                     out_valid, in_ready, busy);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_accept: busy=%b in_ready=%b want 1 0", busy, in_ready);
        end
        n = 0;
        while (!out_valid && n < 60) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b1 || state_out !== C63) begin
            errors++;
            $display("FAIL bp_second_result: out_valid=%b state_out=%h want 1 %h", out_valid, state_out, C63);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_busy;
        logic [127:0] res;
        int lat, bcnt;
        state_in  = SEQ_IN;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || state_out !== 128'h0) begin
            errors++;
            $display("FAIL midreset_async: in_ready=%b out_valid=%b busy=%b state_out=%h want 0 0 0 0",
                     in_ready, out_valid, busy, state_out);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_one(FIPS_IN, res, lat, bcnt);
        checks++;
        if (res !== FIPS_OUT || lat !== LAT) begin
            errors++;
            $display("FAIL midreset_recovery: got %h lat %0d want %h lat %0d", res, lat, FIPS_OUT, LAT);
        end
    endtask

    task automatic test_back_to_back;
        logic [127:0] vin  [3];
        logic [127:0] vexp [3];
        logic [127:0] got  [3];
        int t [3];
        int vi, ri, cyc;
        logic acc;
        vin[0] = FIPS_IN; vexp[0] = FIPS_OUT;
        vin[1] = SEQ_IN;  vexp[1] = SEQ_OUT;
        vin[2] = C8F;     vexp[2] = C73;
        for (int i = 0; i < 3; i++) begin
            got[i] = '0;
            t[i]   = 0;
        end
        vi = 0; ri = 0; cyc = 0;
        state_in  = vin[0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        acc = in_ready;
        while (ri < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (acc) begin
                vi++;
                if (vi < 3) state_in = vin[vi];
                else        in_valid = 1'b0;
            end
            acc = in_ready && in_valid;
            if (out_valid) begin
                got[ri] = state_out;
                t[ri]   = cyc;
                ri++;
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== vexp[i]) begin
                errors++;
                $display("FAIL b2b_result %0d: got %h want %h", i, got[i], vexp[i]);
            end
        end
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (t[i] - t[i-1] !== LAT + 2) begin
                errors++;
                $display("FAIL b2b_spacing %0d: got %0d want %0d", i, t[i] - t[i-1], LAT + 2);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; state_in = '0;
        @(negedge clk);
        test_reset;
        test_fips;
        test_const;
        test_backpressure;
        test_reset_mid_busy;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
